// File: rtl/neo_pixel_strand_receiver_if.sv
// rtl/neo_pixel_strand_receiver_if.sv - serial line and decoded pixel/frame outputs of the strand receiver
// NEO_RX_ERR_COUNT_EN adds err_count to the bundle.
interface neo_pixel_strand_receiver_if;
  logic        neo_in;
  logic [23:0] pixel_data;
  logic [2:0]  pixel_index;
  logic        pixel_valid;
  logic        frame_done;
  logic        frame_error;
  logic        bit_error;
  logic        busy;
`ifdef NEO_RX_ERR_COUNT_EN
  logic [7:0]  err_count;

  modport master (output neo_in, input pixel_data, pixel_index, pixel_valid,
                  frame_done, frame_error, bit_error, busy, err_count);
  modport slave  (input neo_in, output pixel_data, pixel_index, pixel_valid,
                  frame_done, frame_error, bit_error, busy, err_count);
`else
  modport master (output neo_in, input pixel_data, pixel_index, pixel_valid,
                  frame_done, frame_error, bit_error, busy);
  modport slave  (input neo_in, output pixel_data, pixel_index, pixel_valid,
                  frame_done, frame_error, bit_error, busy);
`endif
endinterface

// File: rtl/neo_pixel_strand_receiver.sv
// rtl/neo_pixel_strand_receiver.sv - NeoPixel single-wire decoder: pulse-width bits, 24-bit pixels, latch gap
// Optional saturating error counter under NEO_RX_ERR_COUNT_EN.
module neo_pixel_strand_receiver #(
  parameter int NUM_PIXELS   = 5,
  parameter int MIN_HIGH     = 8,
  parameter int BIT_THRESH   = 27,
  parameter int MAX_HIGH     = 60,
  parameter int LATCH_CYCLES = 2000
) (
  input logic                        clock,
  input logic                        reset_n,
  neo_pixel_strand_receiver_if.slave bus
);
  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_e;

  localparam logic [6:0]  MIN_H  = 7'(MIN_HIGH);
  localparam logic [6:0]  THRESH = 7'(BIT_THRESH);
  localparam logic [6:0]  MAX_H  = 7'(MAX_HIGH);
  localparam logic [11:0] LATCH  = 12'(LATCH_CYCLES);
  localparam logic [3:0]  NPIX   = 4'(NUM_PIXELS);

  state_e      state_q, state_d;
  logic        sync1_q, s_q;
  logic [6:0]  high_cnt_q, high_cnt_d, high_inc;
  logic [11:0] low_cnt_q, low_cnt_d, low_inc;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  pix_cnt_q, pix_cnt_d;
  logic        ovf_q, ovf_d;
  logic [23:0] shreg_q, shreg_d, shifted;
  logic [23:0] pixel_data_q, pixel_data_d;
  logic [2:0]  pixel_index_q, pixel_index_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_error_q, frame_error_d;
  logic        bit_error_q, bit_error_d;

  assign high_inc = (high_cnt_q >= MAX_H) ? MAX_H : high_cnt_q + 7'd1;
  assign low_inc  = (low_cnt_q >= LATCH) ? LATCH : low_cnt_q + 12'd1;
  // LSB-first stream: each bit enters at the top so the first bit lands in bit 0
  assign shifted  = {(high_cnt_q >= THRESH), shreg_q[23:1]};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_SYNC;
      sync1_q       <= 1'b0;
      s_q           <= 1'b0;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      pix_cnt_q     <= '0;
      ovf_q         <= 1'b0;
      shreg_q       <= '0;
      pixel_data_q  <= '0;
      pixel_index_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      bit_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= bus.neo_in;
      s_q           <= sync1_q;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      ovf_q         <= ovf_d;
      shreg_q       <= shreg_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      bit_error_q   <= bit_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    ovf_d         = ovf_q;
    shreg_d       = shreg_q;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    bit_error_d   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (s_q) begin
          low_cnt_d = '0;
        end else begin
          low_cnt_d = low_inc;
          if (low_inc >= LATCH) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (s_q) begin
          state_d    = ST_HIGH;
          high_cnt_d = 7'd1;
          bit_cnt_d  = '0;
          pix_cnt_d  = '0;
          ovf_d      = 1'b0;
        end
      end
      ST_HIGH: begin
        if (s_q) begin
          high_cnt_d = high_inc;
          if (high_inc >= MAX_H) begin
            bit_error_d = 1'b1;
            state_d     = ST_SYNC;
            low_cnt_d   = '0;
          end
        end else if (high_cnt_q < MIN_H) begin
          bit_error_d = 1'b1;
          state_d     = ST_SYNC;
          low_cnt_d   = '0;
        end else begin
          shreg_d   = shifted;
          state_d   = ST_LOW;
          low_cnt_d = 12'd1;
          // a bit arriving after NUM_PIXELS whole pixels marks the frame as overflowed
          if (pix_cnt_q == NPIX) ovf_d = 1'b1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            if (pix_cnt_q < NPIX) begin
              pixel_data_d  = shifted;
              pixel_index_d = pix_cnt_q[2:0];
              pixel_valid_d = 1'b1;
              pix_cnt_d     = pix_cnt_q + 4'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      ST_LOW: begin
        if (s_q) begin
          state_d    = ST_HIGH;
          high_cnt_d = 7'd1;
        end else begin
          low_cnt_d = low_inc;
          if (low_inc >= LATCH) begin
            state_d       = ST_IDLE;
            frame_done_d  = 1'b1;
            frame_error_d = (bit_cnt_q != 5'd0) || ovf_q;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign bus.pixel_data  = pixel_data_q;
  assign bus.pixel_index = pixel_index_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_error = frame_error_q;
  assign bus.bit_error   = bit_error_q;
  assign bus.busy        = (state_q == ST_HIGH) || (state_q == ST_LOW);

`ifdef NEO_RX_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  assign err_count_d = ((bit_error_d || frame_error_d) && (err_count_q != 8'hFF))
                       ? err_count_q + 8'd1 : err_count_q;

  always_ff @(posedge clock) begin
    if (!reset_n) err_count_q <= '0;
    else          err_count_q <= err_count_d;
  end

  assign bus.err_count = err_count_q;
`endif
endmodule

// File: tb/tb_neo_pixel_strand_receiver.sv
// tb/tb_neo_pixel_strand_receiver.sv - directed bench for the NeoPixel strand receiver
// Optional err_count checks compile in with NEO_RX_ERR_COUNT_EN.
module tb_neo_pixel_strand_receiver;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_fall = 0;

  neo_pixel_strand_receiver_if bus();

  neo_pixel_strand_receiver dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc++;

  logic [23:0] pix_data_log[$];
  int          pix_idx_log[$];
  int          pix_cyc_log[$];
  int          pix_fall[$];
  int          fd_cyc_log[$];
  int          fd_err_log[$];
  int          be_n = 0;

  always @(negedge clock) begin
    if (bus.pixel_valid === 1'b1) begin
      pix_data_log.push_back(bus.pixel_data);
      pix_idx_log.push_back(int'(bus.pixel_index));
      pix_cyc_log.push_back(cyc);
    end
    if (bus.frame_done === 1'b1) begin
      fd_cyc_log.push_back(cyc);
      fd_err_log.push_back(int'(bus.frame_error));
    end
    if (bus.bit_error === 1'b1) be_n++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_logs;
    pix_data_log.delete(); pix_idx_log.delete(); pix_cyc_log.delete();
    pix_fall.delete(); fd_cyc_log.delete(); fd_err_log.delete();
    be_n = 0;
  endtask

  task automatic send_bit(input logic b);
    bus.neo_in = 1'b1;
    tick(b ? 36 : 19);
    bus.neo_in = 1'b0;
    last_fall = cyc;
    tick(b ? 30 : 40);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic send_pixel(input logic [23:0] w);
    send_bits(w, 24);
    pix_fall.push_back(last_fall);
  endtask

  task automatic test_reset;
    bus.neo_in = 1'b0;
    reset_n = 1'b0;
    tick(2);
    n_checks++;
    if ({bus.pixel_data, bus.pixel_index, bus.pixel_valid, bus.frame_done,
         bus.frame_error, bus.bit_error, bus.busy} !== 31'd0) begin
      $display("FAIL reset_outputs: got data=%h idx=%0d pv=%b fd=%b fe=%b be=%b busy=%b, expected all 0",
               bus.pixel_data, bus.pixel_index, bus.pixel_valid, bus.frame_done,
               bus.frame_error, bus.bit_error, bus.busy);
      n_fail++;
    end
`ifdef NEO_RX_ERR_COUNT_EN
    n_checks++;
    if (bus.err_count !== 8'd0) begin
      $display("FAIL reset_err_count: got %0d expected 0", bus.err_count); n_fail++;
    end
`endif
    reset_n = 1'b1;
    tick(2000);
  endtask

  task automatic test_sync_first_pixel;
    clear_logs();
    send_pixel(24'h00FF00);
    tick(2500);
    n_checks++;
    if (pix_data_log.size() != 1) begin
      $display("FAIL sync_pixel_count: got %0d expected 1", pix_data_log.size()); n_fail++;
    end else begin
      n_checks += 3;
      if (pix_data_log[0] !== 24'h00FF00) begin
        $display("FAIL sync_pixel_data: got %h expected 00ff00", pix_data_log[0]); n_fail++;
      end
      if (pix_idx_log[0] != 0) begin
        $display("FAIL sync_pixel_index: got %0d expected 0", pix_idx_log[0]); n_fail++;
      end
      if (pix_cyc_log[0] != pix_fall[0] + 3) begin
        $display("FAIL sync_pixel_latency: got %0d expected %0d", pix_cyc_log[0] - pix_fall[0], 3); n_fail++;
      end
    end
    n_checks++;
    if (fd_err_log.size() != 1 || fd_err_log[0] != 0) begin
      $display("FAIL sync_frame_done: got %0d strobes expected 1 clean", fd_err_log.size()); n_fail++;
    end
  endtask

  task automatic test_full_frame;
    logic [23:0] px [5];
    px = '{24'h123456, 24'hABCDEF, 24'h000001, 24'h800000, 24'hFFFFFF};
    clear_logs();
    for (int i = 0; i < 5; i++) send_pixel(px[i]);
    tick(2500);
    n_checks++;
    if (pix_data_log.size() != 5) begin
      $display("FAIL full_pixel_count: got %0d expected 5", pix_data_log.size()); n_fail++;
    end
    for (int i = 0; i < 5 && i < pix_data_log.size(); i++) begin
      n_checks += 3;
      if (pix_data_log[i] !== px[i]) begin
        $display("FAIL full_pixel_data[%0d]: got %h expected %h", i, pix_data_log[i], px[i]); n_fail++;
      end
      if (pix_idx_log[i] != i) begin
        $display("FAIL full_pixel_index[%0d]: got %0d expected %0d", i, pix_idx_log[i], i); n_fail++;
      end
      if (pix_cyc_log[i] != pix_fall[i] + 3) begin
        $display("FAIL full_pixel_latency[%0d]: got %0d expected 3", i, pix_cyc_log[i] - pix_fall[i]); n_fail++;
      end
    end
    n_checks++;
    if (fd_cyc_log.size() != 1) begin
      $display("FAIL full_frame_done_count: got %0d expected 1", fd_cyc_log.size()); n_fail++;
    end else begin
      n_checks += 2;
      if (fd_err_log[0] != 0) begin
        $display("FAIL full_frame_error: got %0d expected 0", fd_err_log[0]); n_fail++;
      end
      if (fd_cyc_log[0] != last_fall + 2002) begin
        $display("FAIL full_frame_done_time: got %0d expected %0d", fd_cyc_log[0] - last_fall, 2002); n_fail++;
      end
    end
    n_checks++;
    if (bus.pixel_data !== 24'hFFFFFF || bus.pixel_index !== 3'd4) begin
      $display("FAIL full_pixel_hold: got %h/%0d expected ffffff/4", bus.pixel_data, bus.pixel_index); n_fail++;
    end
  endtask

  task automatic test_partial_frame;
    clear_logs();
    send_pixel(24'h5A5A5A);
    send_bits(24'h00003F, 6);
    tick(2500);
    n_checks += 2;
    if (pix_data_log.size() != 1 || pix_data_log[0] !== 24'h5A5A5A) begin
      $display("FAIL partial_pixels: got %0d strobes expected 1 of 5a5a5a", pix_data_log.size()); n_fail++;
    end
    if (fd_err_log.size() != 1 || fd_err_log[0] != 1) begin
      $display("FAIL partial_frame_error: got %0d strobes expected 1 with frame_error=1", fd_err_log.size()); n_fail++;
    end
`ifdef NEO_RX_ERR_COUNT_EN
    n_checks++;
    if (bus.err_count !== 8'd1) begin
      $display("FAIL partial_err_count: got %0d expected 1", bus.err_count); n_fail++;
    end
`endif
    clear_logs();
    send_pixel(24'hC0FFEE);
    send_pixel(24'h0F0F0F);
    tick(2500);
    n_checks += 2;
    if (pix_data_log.size() != 2 || pix_data_log[0] !== 24'hC0FFEE || pix_data_log[1] !== 24'h0F0F0F
        || pix_idx_log[1] != 1) begin
      $display("FAIL after_partial_pixels: got %0d strobes expected c0ffee,0f0f0f at 0,1", pix_data_log.size()); n_fail++;
    end
    if (fd_err_log.size() != 1 || fd_err_log[0] != 0) begin
      $display("FAIL after_partial_frame: got %0d strobes expected 1 clean", fd_err_log.size()); n_fail++;
    end
  endtask

  task automatic test_overflow;
    clear_logs();
    for (int i = 0; i < 6; i++) send_pixel(24'h010101 * (i + 1));
    tick(2500);
    n_checks += 3;
    if (pix_data_log.size() != 5) begin
      $display("FAIL overflow_pixel_count: got %0d expected 5", pix_data_log.size()); n_fail++;
    end
    if (pix_data_log.size() != 0 && (pix_data_log[pix_data_log.size()-1] !== 24'h050505
        || pix_idx_log[pix_idx_log.size()-1] != 4)) begin
      $display("FAIL overflow_last_pixel: got %h expected 050505 at index 4", pix_data_log[pix_data_log.size()-1]); n_fail++;
    end
    if (fd_err_log.size() != 1 || fd_err_log[0] != 1) begin
      $display("FAIL overflow_frame_error: got %0d strobes expected 1 with frame_error=1", fd_err_log.size()); n_fail++;
    end
`ifdef NEO_RX_ERR_COUNT_EN
    n_checks++;
    if (bus.err_count !== 8'd2) begin
      $display("FAIL overflow_err_count: got %0d expected 2", bus.err_count); n_fail++;
    end
`endif
  endtask

  task automatic test_glitch(input int width, input int exp_err);
    clear_logs();
    send_pixel(24'h13579B);
    send_bits(24'h2468AC, 12);
    bus.neo_in = 1'b1;
    tick(width);
    bus.neo_in = 1'b0;
    tick(40);
    send_bits(24'h2468AC, 12);
    send_pixel(24'hFEDCBA);
    tick(2500);
    n_checks += 3;
    if (be_n != 1) begin
      $display("FAIL glitch%0d_bit_error: got %0d strobes expected 1", width, be_n); n_fail++;
    end
    if (pix_data_log.size() != 1 || pix_data_log[0] !== 24'h13579B) begin
      $display("FAIL glitch%0d_pixels: got %0d strobes expected only 13579b", width, pix_data_log.size()); n_fail++;
    end
    if (fd_cyc_log.size() != 0) begin
      $display("FAIL glitch%0d_no_frame_done: got %0d expected 0", width, fd_cyc_log.size()); n_fail++;
    end
`ifdef NEO_RX_ERR_COUNT_EN
    n_checks++;
    if (int'(bus.err_count) != exp_err) begin
      $display("FAIL glitch%0d_err_count: got %0d expected %0d", width, bus.err_count, exp_err); n_fail++;
    end
`endif
    clear_logs();
    send_pixel(24'h00A5F0);
    tick(2500);
    n_checks += 2;
    if (pix_data_log.size() != 1 || pix_data_log[0] !== 24'h00A5F0 || pix_idx_log[0] != 0) begin
      $display("FAIL glitch%0d_recovery_pixel: got %0d strobes expected 00a5f0 at 0", width, pix_data_log.size()); n_fail++;
    end
    if (fd_err_log.size() != 1 || fd_err_log[0] != 0) begin
      $display("FAIL glitch%0d_recovery_frame: got %0d strobes expected 1 clean", width, fd_err_log.size()); n_fail++;
    end
  endtask

  task automatic test_reset_mid_frame;
    clear_logs();
    send_bits(24'hABCDEF, 12);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      $display("FAIL midframe_busy: got %b expected 1", bus.busy); n_fail++;
    end
    reset_n = 1'b0;
    tick(1);
    n_checks++;
    if ({bus.pixel_data, bus.pixel_index, bus.pixel_valid, bus.frame_done,
         bus.frame_error, bus.bit_error, bus.busy} !== 31'd0) begin
      $display("FAIL midframe_reset_outputs: got data=%h idx=%0d busy=%b expected all 0",
               bus.pixel_data, bus.pixel_index, bus.busy);
      n_fail++;
    end
`ifdef NEO_RX_ERR_COUNT_EN
    n_checks++;
    if (bus.err_count !== 8'd0) begin
      $display("FAIL midframe_err_count: got %0d expected 0", bus.err_count); n_fail++;
    end
`endif
    reset_n = 1'b1;
    send_bits(24'hABCDEF >> 12, 12);
    send_pixel(24'h55AA33);
    tick(2500);
    n_checks++;
    if (pix_data_log.size() != 0 || fd_cyc_log.size() != 0 || be_n != 0) begin
      $display("FAIL midframe_ignored: got %0d pixels %0d frames %0d errors expected none",
               pix_data_log.size(), fd_cyc_log.size(), be_n);
      n_fail++;
    end
    clear_logs();
    send_pixel(24'h0000FF);
    tick(2500);
    n_checks += 2;
    if (pix_data_log.size() != 1 || pix_data_log[0] !== 24'h0000FF || pix_idx_log[0] != 0) begin
      $display("FAIL midframe_recovery_pixel: got %0d strobes expected 0000ff at 0", pix_data_log.size()); n_fail++;
    end
    if (fd_err_log.size() != 1 || fd_err_log[0] != 0) begin
      $display("FAIL midframe_recovery_frame: got %0d strobes expected 1 clean", fd_err_log.size()); n_fail++;
    end
  endtask

  initial begin
    bus.neo_in = 1'b0;
    test_reset();
    test_sync_first_pixel();
    test_full_frame();
    test_partial_frame();
    test_overflow();
    test_glitch(5, 3);
    test_glitch(70, 4);
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
